// File: rtl/beu_clmul_seq_if.sv
// Request/response bundle between the executor and the carry-less multiply sequencer.
// Signal names match the legacy flat ports so existing hookups map one-to-one.
interface beu_clmul_seq_if;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [1:0]  s_function_i;
    logic [31:0] s_op1_i;
    logic [31:0] s_op2_i;
    logic        s_kill_i;
    logic        s_valid_o;
    logic        s_ready_i;
    logic [31:0] s_result_o;
    logic        s_busy_o;

    modport master (
        output s_valid_i, s_function_i, s_op1_i, s_op2_i, s_kill_i, s_ready_i,
        input  s_ready_o, s_valid_o, s_result_o, s_busy_o
    );

    modport slave (
        input  s_valid_i, s_function_i, s_op1_i, s_op2_i, s_kill_i, s_ready_i,
        output s_ready_o, s_valid_o, s_result_o, s_busy_o
    );
endinterface

// File: rtl/beu_clmul_seq.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr): consumes BITS_PER_CYCLE
// multiplier bits per RUN cycle into a 64-bit accumulator, fixed latency.
module beu_clmul_seq #(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input logic                 s_clk_i,
    input logic                 s_rst_i,
    beu_clmul_seq_if.slave      bus
);
    localparam int unsigned NCHUNK = 32 / BITS_PER_CYCLE;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      acc_q;
    logic [63:0]      mcand_q;
    logic [31:0]      mplier_q;
    logic [1:0]       func_q;
    logic [63:0]      partial;
    logic [31:0]      result;
    logic             accept;

    assign accept = bus.s_valid_i & (state_q == ST_IDLE) & ~bus.s_kill_i;

    // Operands are kept pre-shifted (multiplicand left, multiplier right) so each
    // cycle only looks at the low chunk instead of indexing by the counter.
    always_comb begin
        logic [BITS_PER_CYCLE-1:0] chunk;
        logic [63:0]               m;
        partial = '0;
        chunk   = mplier_q[BITS_PER_CYCLE-1:0];
        m       = mcand_q;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (chunk[0]) partial = partial ^ m;
            chunk = chunk >> 1;
            m     = m << 1;
        end
    end

    always_ff @(posedge s_clk_i or posedge s_rst_i) begin
        if (s_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            func_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_RUN;
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        mcand_q  <= {32'b0, bus.s_op1_i};
                        mplier_q <= bus.s_op2_i;
                        func_q   <= bus.s_function_i;
                    end
                end
                ST_RUN: begin
                    if (bus.s_kill_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q    <= acc_q ^ partial;
                        mcand_q  <= mcand_q << BITS_PER_CYCLE;
                        mplier_q <= mplier_q >> BITS_PER_CYCLE;
                        cnt_q    <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CHUNK) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.s_kill_i || bus.s_ready_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        result = '0;
        if (state_q == ST_DONE) begin
            case (func_q)
                2'b00:   result = acc_q[31:0];
                2'b01:   result = acc_q[63:32];
                2'b10:   result = acc_q[62:31];
                default: result = '0;
            endcase
        end
    end

    assign bus.s_ready_o  = (state_q == ST_IDLE);
    assign bus.s_valid_o  = (state_q == ST_DONE);
    assign bus.s_busy_o   = (state_q != ST_IDLE);
    assign bus.s_result_o = result;
endmodule
